// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/result handshake bundle for serial_adder
// master drives the request and operands; slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  ready, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor, DIGIT bits per clock, LSB first
// Result registers only change on the final digit so sum never shows partial shifting.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_shift;
  logic             last_digit;
  logic             msb_a, msb_b, msb_r;

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign last_digit = (cnt_q == LAST);

  // Same-sign operands producing an opposite-sign result is carry-into-MSB xor carry-out.
  assign msb_a = a_q[DIGIT-1];
  assign msb_b = b_q[DIGIT-1];
  assign msb_r = dsum[DIGIT-1];

  generate
    if (DIGIT == WIDTH) begin : g_one_step
      assign acc_shift = dsum[DIGIT-1:0];
    end else begin : g_multi_step
      assign acc_shift = {dsum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          sum_d  = acc_shift;
          cout_d = dsum[DIGIT];
          ovf_d  = (msb_a ~^ msb_b) & (msb_r ^ msb_a);
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.cout  = cout_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder (DIGIT=1 and DIGIT=4)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4, cin, sub;
  logic [7:0] a, b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if1 ();
  serial_adder_if #(.WIDTH(8)) if4 ();

  assign if1.start = start1;
  assign if1.a     = a;
  assign if1.b     = b;
  assign if1.cin   = cin;
  assign if1.sub   = sub;
  assign if4.start = start4;
  assign if4.a     = a;
  assign if4.b     = b;
  assign if4.cin   = cin;
  assign if4.sub   = sub;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // Reference: {ovf, cout, sum} from integer arithmetic on unsigned and signed views.
  function automatic logic [9:0] model(input logic [7:0] ma, mb, input logic mcin, msub);
    int ua, ub, sa, sb, ci, r, sr;
    logic co, ov;
    logic [7:0] s;
    ua = ma; ub = mb; sa = $signed(ma); sb = $signed(mb); ci = mcin;
    if (msub) begin
      r = ua - ub; sr = sa - sb; co = (ua >= ub);
    end else begin
      r = ua + ub + ci; sr = sa + sb + ci; co = (r > 255);
    end
    s  = r[7:0];
    ov = (sr > 127) || (sr < -128);
    return {ov, co, s};
  endfunction

  task automatic run_op(input bit sel, input logic [7:0] ta, tb, input logic tcin, tsub,
                        input int glitch, output int lat, output logic [9:0] res, output bit held);
    logic [7:0] s0;
    int n;
    bit seen;
    s0 = sel ? if4.sum : if1.sum;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    n = 0; seen = 0; held = 1; lat = -1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      start1 = 1'b0; start4 = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (n == glitch) begin
        if (sel) start4 = 1'b1; else start1 = 1'b1;
      end
      if (sel ? if4.done : if1.done) begin
        seen = 1; lat = n - 1;
      end else if ((sel ? if4.sum : if1.sum) !== s0) begin
        held = 0;
      end
    end
    res = sel ? {if4.ovf, if4.cout, if4.sum} : {if1.ovf, if1.cout, if1.sum};
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout sel=%0d a=%h b=%h: no done within 40 cycles", sel, ta, tb);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks += 6;
    if (if1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if1.ready); end
    if (if1.done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", if1.done); end
    if (if1.sum !== 8'h00)  begin errors++; $display("FAIL reset_sum got %h want 00", if1.sum); end
    if (if1.cout !== 1'b0)  begin errors++; $display("FAIL reset_cout got %b want 0", if1.cout); end
    if (if1.ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", if1.ovf); end
    if (if4.ready !== 1'b1) begin errors++; $display("FAIL reset_ready4 got %b want 1", if4.ready); end
  endtask

  task automatic test_directed;
    logic [7:0] va [5] = '{8'h3C, 8'hFF, 8'h00, 8'h05, 8'h80};
    logic [7:0] vb [5] = '{8'h5A, 8'h01, 8'h00, 8'h07, 8'h01};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] ve [5] = '{{2'b10, 8'h96}, {2'b01, 8'h00}, {2'b00, 8'h01},
                           {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    int lat;
    logic [9:0] res;
    bit held;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, va[i], vb[i], vc[i], vs[i], 0, lat, res, held);
      checks += 3;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL directed_%0d {ovf,cout,sum} got %b_%b_%h want %b_%b_%h",
                 i, res[9], res[8], res[7:0], ve[i][9], ve[i][8], ve[i][7:0]);
      end
      if (lat != 8) begin errors++; $display("FAIL directed_lat_%0d got %0d want 8", i, lat); end
      if (!held) begin errors++; $display("FAIL directed_sum_held_%0d sum changed before done", i); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    logic [9:0] res;
    bit held;
    run_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 3, lat, res, held);
    checks += 4;
    if (res !== {2'b00, 8'h46}) begin
      errors++; $display("FAIL ignore_start result got %b_%b_%h want 0_0_46", res[9], res[8], res[7:0]);
    end
    if (lat != 8) begin errors++; $display("FAIL ignore_start_lat got %0d want 8", lat); end
    if (if1.ready !== 1'b0) begin errors++; $display("FAIL ready_during_done got %b want 0", if1.ready); end
    if (!held) begin errors++; $display("FAIL ignore_start_held sum changed before done"); end
    @(negedge clk);
    checks += 3;
    if (if1.ready !== 1'b1) begin errors++; $display("FAIL ready_after_done got %b want 1", if1.ready); end
    if (if1.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", if1.done); end
    if (if1.sum !== 8'h46) begin errors++; $display("FAIL sum_hold_after_done got %h want 46", if1.sum); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [9:0] res, exp;
    bit held;
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; sub = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (if1.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", if1.ready); end
    if (if1.done !== 1'b0)  begin errors++; $display("FAIL midrst_done got %b want 0", if1.done); end
    if (if1.sum !== 8'h00)  begin errors++; $display("FAIL midrst_sum got %h want 00", if1.sum); end
    if (if1.cout !== 1'b0)  begin errors++; $display("FAIL midrst_cout got %b want 0", if1.cout); end
    if (if1.ovf !== 1'b0)   begin errors++; $display("FAIL midrst_ovf got %b want 0", if1.ovf); end
    run_op(1'b0, 8'hC8, 8'h64, 1'b1, 1'b0, 0, lat, res, held);
    exp = model(8'hC8, 8'h64, 1'b1, 1'b0);
    checks++;
    if (res !== exp) begin errors++; $display("FAIL midrst_next_op got %h want %h", res, exp); end
    @(negedge clk);
    rst = 1'b1; start1 = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.ready !== 1'b1) begin errors++; $display("FAIL rst_beats_start ready got %b want 1", if1.ready); end
  endtask

  task automatic test_random(input bit sel, input int count, input int steps);
    int lat;
    logic [9:0] res, exp;
    logic [7:0] ra, rb;
    logic rc, rs;
    bit held;
    for (int i = 0; i < count; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = (i % 2 == 1);
      run_op(sel, ra, rb, rc, rs, 0, lat, res, held);
      exp = model(ra, rb, rc, rs);
      checks += 2;
      if (res !== exp) begin
        errors++;
        $display("FAIL random_d%0d a=%h b=%h cin=%b sub=%b got %h want %h",
                 sel ? 4 : 1, ra, rb, rc, rs, res, exp);
      end
      if (lat != steps) begin
        errors++; $display("FAIL random_lat_d%0d got %0d want %0d", sel ? 4 : 1, lat, steps);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_reset_mid;
    test_random(1'b0, 20, 8);
    test_random(1'b1, 200, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
